// File: rtl/tlul_fuzz_host_pkg.sv
// TL-UL bus types plus the fuzz-host instruction, opcode and state types.
// Both packages live here so every consumer sees one consistent definition.
package tlul_pkg;

    localparam int unsigned TlAw  = 32;
    localparam int unsigned TlDw  = 32;
    localparam int unsigned TlDbw = 4;
    localparam int unsigned TlAiw = 8;
    localparam int unsigned TlDiw = 1;
    localparam int unsigned TlSzw = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef logic [13:0] tl_a_user_t;

    localparam tl_a_user_t TlAUserDefault = '0;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TlSzw-1:0]  a_size;
        logic [TlAiw-1:0]  a_source;
        logic [TlAw-1:0]   a_address;
        logic [TlDbw-1:0]  a_mask;
        logic [TlDw-1:0]   a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TlSzw-1:0]  d_size;
        logic [TlAiw-1:0]  d_source;
        logic [TlDiw-1:0]  d_sink;
        logic [TlDw-1:0]   d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

package tlul_fuzz_pkg;

    import tlul_pkg::*;

    localparam int unsigned FuzzWaitW = 16;

    typedef enum logic [1:0] {
        OpWait         = 2'd0,
        OpRead         = 2'd1,
        OpWrite        = 2'd2,
        OpWritePartial = 2'd3
    } fuzz_op_e;

    typedef struct packed {
        fuzz_op_e    opcode;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } fuzz_instr_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StTimeout
    } fuzz_state_e;

    // Source-ID width never collapses to zero for a single-slot host.
    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic tl_a_op_e a_opcode_of(input fuzz_op_e op);
        case (op)
            OpWrite:        return PutFullData;
            OpWritePartial: return PutPartialData;
            default:        return Get;
        endcase
    endfunction

    function automatic logic [3:0] a_mask_of(input fuzz_instr_t ins);
        return (ins.opcode == OpWritePartial) ? ins.mask : 4'hF;
    endfunction

endpackage

// File: rtl/tlul_fuzz_host_if.sv
// TL-UL request/response bundle between the fuzz host and a device under test.
interface tlul_fuzz_host_if;
    import tlul_pkg::*;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    modport master (output h2d, input d2h);
    modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_fuzz_srcid_alloc.sv
// Source-ID bitmap: hands out the lowest free ID and retires IDs on D beats.
module tlul_fuzz_srcid_alloc
    import tlul_pkg::*;
    import tlul_fuzz_pkg::*;
#(
    parameter int unsigned NumIds = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      i_alloc,
    input  logic                      i_free_req,
    input  logic [TlAiw-1:0]          i_free_src,
    output logic [src_w(NumIds)-1:0]  o_alloc_id,
    output logic                      o_full,
    output logic                      o_free_hit,
    output logic [cnt_w(NumIds)-1:0]  o_count
);

    localparam int unsigned SrcW = src_w(NumIds);
    localparam int unsigned CntW = cnt_w(NumIds);

    logic [NumIds-1:0] r_busy;
    logic [CntW-1:0]   r_count;
    logic              w_found;
    logic              w_hit;
    logic [SrcW-1:0]   w_lowest;

    // Lowest-free priority encoder and in-flight lookup of the returning source.
    always_comb begin
        w_found  = 1'b0;
        w_lowest = '0;
        w_hit    = 1'b0;
        for (int i = 0; i < int'(NumIds); i++) begin
            if (!r_busy[i] && !w_found) begin
                w_found  = 1'b1;
                w_lowest = SrcW'(i);
            end
            if (i_free_src == TlAiw'(i)) begin
                w_hit = r_busy[i];
            end
        end
    end

    assign o_alloc_id = w_lowest;
    assign o_full     = &r_busy;
    assign o_free_hit = i_free_req && w_hit;
    assign o_count    = r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < int'(NumIds); i++) begin
                if (i_alloc && (w_lowest == SrcW'(i))) begin
                    r_busy[i] <= 1'b1;
                end
                if (o_free_hit && (i_free_src == TlAiw'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            case ({i_alloc, o_free_hit})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tlul_fuzz_host.sv
// TL-UL host that turns decoded fuzz instructions into Get/Put requests,
// tracks in-flight sources, reports responses and watches for a stalled device.
module tlul_fuzz_host
    import tlul_pkg::*;
    import tlul_fuzz_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               instr_valid_i,
    output logic                               instr_ready_o,
    input  fuzz_instr_t                        instr_i,
    output tl_h2d_t                            tl_o,
    input  tl_d2h_t                            tl_i,
    output logic                               rsp_valid_o,
    output logic [31:0]                        rsp_data_o,
    output logic                               rsp_err_o,
    output logic [src_w(MaxOutstanding)-1:0]   rsp_source_o,
    output logic [cnt_w(MaxOutstanding)-1:0]   outstanding_o,
    output logic                               busy_o,
    output logic                               bad_rsp_o,
    output logic                               timeout_o
);

    localparam int unsigned SrcW = src_w(MaxOutstanding);
    localparam int unsigned CntW = cnt_w(MaxOutstanding);
    localparam int unsigned WdW  = $clog2(TimeoutCycles + 1);

    fuzz_state_e          r_state;
    logic                 r_run;
    logic                 r_a_valid;
    tl_a_op_e             r_a_opcode;
    logic [SrcW-1:0]      r_a_source;
    logic [31:0]          r_a_address;
    logic [31:0]          r_a_data;
    logic [3:0]           r_a_mask;
    logic [FuzzWaitW-1:0] r_wait_cnt;
    logic [WdW-1:0]       r_wd_cnt;
    logic                 r_timeout;
    logic                 r_bad_rsp;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_data;
    logic                 r_rsp_err;
    logic [SrcW-1:0]      r_rsp_source;

    logic                 w_d_beat;
    logic                 w_is_rw;
    logic                 w_can_take;
    logic                 w_accept;
    logic                 w_alloc;
    logic                 w_full;
    logic                 w_free_hit;
    logic                 w_wd_fire;
    logic [SrcW-1:0]      w_alloc_id;
    logic [CntW-1:0]      w_count;
    logic [FuzzWaitW-1:0] w_wait_n;
    logic                 w_unused;

    assign w_d_beat   = tl_i.d_valid;
    assign w_is_rw    = (instr_i.opcode != OpWait);
    assign w_wait_n   = instr_i.data[FuzzWaitW-1:0];
    assign w_can_take = (r_state == StIdle) || ((r_state == StIssue) && tl_i.a_ready);
    // r_run keeps the handshake closed until the first clock after reset release.
    assign instr_ready_o = r_run && w_can_take && !w_full && !w_wd_fire;
    assign w_accept   = instr_valid_i && instr_ready_o;
    assign w_alloc    = w_accept && w_is_rw;
    assign w_wd_fire  = (w_count != '0) && !w_d_beat && (r_wd_cnt == WdW'(TimeoutCycles - 1));
    assign w_unused   = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink, instr_i.addr[1:0]};

    tlul_fuzz_srcid_alloc #(
        .NumIds (MaxOutstanding)
    ) u_srcid_alloc (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_alloc    (w_alloc),
        .i_free_req (w_d_beat),
        .i_free_src (tl_i.d_source),
        .o_alloc_id (w_alloc_id),
        .o_full     (w_full),
        .o_free_hit (w_free_hit),
        .o_count    (w_count)
    );

    // Watchdog counts only while something is in flight and the D channel is silent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= '0;
        end else if ((w_count == '0) || w_d_beat) begin
            r_wd_cnt <= '0;
        end else if (!w_wd_fire) begin
            r_wd_cnt <= r_wd_cnt + WdW'(1);
        end
    end

    // Response capture and sticky status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_source <= '0;
            r_bad_rsp    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_rsp_valid <= w_d_beat;
            if (w_d_beat) begin
                r_rsp_data   <= tl_i.d_data;
                r_rsp_err    <= tl_i.d_error;
                r_rsp_source <= SrcW'(tl_i.d_source);
            end
            if (w_d_beat && !w_free_hit) begin
                r_bad_rsp <= 1'b1;
            end
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Request FSM; A-channel fields are held stable while a_valid waits on a_ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_a_valid   <= 1'b0;
            r_a_opcode  <= PutFullData;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_data    <= '0;
            r_a_mask    <= '0;
            r_wait_cnt  <= '0;
        end else if (w_wd_fire || (r_state == StTimeout)) begin
            r_state   <= StTimeout;
            r_a_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StIssue: begin
                    if ((r_state == StIdle) || tl_i.a_ready) begin
                        r_a_valid <= 1'b0;
                        r_state   <= StIdle;
                        if (w_alloc) begin
                            r_state     <= StIssue;
                            r_a_valid   <= 1'b1;
                            r_a_opcode  <= a_opcode_of(instr_i.opcode);
                            r_a_source  <= w_alloc_id;
                            r_a_address <= {instr_i.addr[31:2], 2'b00};
                            r_a_data    <= (instr_i.opcode == OpRead) ? 32'h0 : instr_i.data;
                            r_a_mask    <= a_mask_of(instr_i);
                        end else if (w_accept && (w_wait_n != '0)) begin
                            r_state    <= StWait;
                            r_wait_cnt <= w_wait_n;
                        end
                    end
                end
                StWait: begin
                    if (r_wait_cnt == FuzzWaitW'(1)) begin
                        r_state <= StIdle;
                    end
                    r_wait_cnt <= r_wait_cnt - FuzzWaitW'(1);
                end
                default: r_state <= StTimeout;
            endcase
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = r_a_valid;
        tl_o.a_opcode  = r_a_opcode;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = r_a_valid ? TlSzw'(2) : TlSzw'(0);
        tl_o.a_source  = TlAiw'(r_a_source);
        tl_o.a_address = r_a_address;
        tl_o.a_mask    = r_a_mask;
        tl_o.a_data    = r_a_data;
        tl_o.a_user    = TlAUserDefault;
        tl_o.d_ready   = 1'b1;
    end

    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_source_o  = r_rsp_source;
    assign outstanding_o = w_count;
    assign busy_o        = (r_state != StIdle) || (w_count != '0);
    assign bad_rsp_o     = r_bad_rsp;
    assign timeout_o     = r_timeout;

endmodule
